// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants for the 7-segment display path
// Holds the digit count, digit-slot width and the segment patterns for 0..9.
// The patterns are shared with the transmit-side decoder.
// Bit order is a..g in bits 7..1 and dp in bit 0.
package display_pkg;

    localparam int NUM_DIGITS = 5;
    localparam int DIGIT_W    = 4;

    localparam logic [7:0] SEG_0 = 8'hFC;
    localparam logic [7:0] SEG_1 = 8'h60;
    localparam logic [7:0] SEG_2 = 8'hDA;
    localparam logic [7:0] SEG_3 = 8'hF2;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'hB6;
    localparam logic [7:0] SEG_6 = 8'hBE;
    localparam logic [7:0] SEG_7 = 8'hE0;
    localparam logic [7:0] SEG_8 = 8'hFE;
    localparam logic [7:0] SEG_9 = 8'hF6;

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - reverse decode of a lit 7-segment pattern to BCD
// Ports:
//   seg     - segments a..g (dp already stripped)
//   digit   - decoded BCD value; 0 when invalid
//   invalid - pattern is not one of the ten digit shapes
module seg7_to_bcd
    import display_pkg::*;
(
    input  logic [6:0]         seg,
    output logic [DIGIT_W-1:0] digit,
    output logic               invalid
);

    always_comb begin
        digit   = '0;
        invalid = 1'b0;
        case (seg)
            SEG_0[7:1]: digit = 4'd0;
            SEG_1[7:1]: digit = 4'd1;
            SEG_2[7:1]: digit = 4'd2;
            SEG_3[7:1]: digit = 4'd3;
            SEG_4[7:1]: digit = 4'd4;
            SEG_5[7:1]: digit = 4'd5;
            SEG_6[7:1]: digit = 4'd6;
            SEG_7[7:1]: digit = 4'd7;
            SEG_8[7:1]: digit = 4'd8;
            SEG_9[7:1]: digit = 4'd9;
            default:    invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/display_capture.sv
// rtl/display_capture.sv - samples a multiplexed 7-segment bus and publishes 5-digit frames
// Ports:
//   clk, reset_n  - clock and asynchronous active-low reset
//   segments      - a..g in bits 7..1, dp in bit 0, active-high
//   cathodes      - one-hot digit select, bit i = digit i
//   digits        - last published frame, digit i at [4i+3:4i]
//   digits_valid  - one-cycle strobe when digits/err update
//   err           - per-slot decode error flags of the last published frame
//   active        - frames are arriving within TIMEOUT_CYCLES
module display_capture
    import display_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    segments,
    input  logic [NUM_DIGITS-1:0]         cathodes,
    output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    output logic                          digits_valid,
    output logic [NUM_DIGITS-1:0]         err,
    output logic                          active
);

    localparam int SAMPLE_W = 8 + NUM_DIGITS;
    localparam int SW       = $clog2(SETTLE_CYCLES);
    localparam int TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_FIRE = TW'(TIMEOUT_CYCLES - 2);

    logic [SAMPLE_W-1:0]           s;
    logic [SAMPLE_W-1:0]           s_prev;
    logic [SW-1:0]                 settle_cnt;
    logic                          captured;
    logic [NUM_DIGITS-1:0]         mask;
    logic [NUM_DIGITS*DIGIT_W-1:0] shadow;
    logic [NUM_DIGITS-1:0]         shadow_err;
    logic [TW-1:0]                 timeout_cnt;

    logic [NUM_DIGITS-1:0]         s_cath;
    logic                          stable;
    logic                          capture;
    logic                          publish;
    logic [DIGIT_W-1:0]            dec_digit;
    logic                          dec_invalid;
    logic [NUM_DIGITS*DIGIT_W-1:0] shadow_next;
    logic [NUM_DIGITS-1:0]         err_next;

    assign s_cath = s[NUM_DIGITS-1:0];
    assign stable = (s == s_prev);

    // stable is required too: the counter still reads its last value on the
    // first cycle after the bus moves, and that new value must not be taken.
    assign capture = stable && (settle_cnt == SETTLE_LAST) && !captured
                     && is_onehot(s_cath);
    assign publish = capture && ((mask | s_cath) == '1);

    seg7_to_bcd u_dec (
        .seg     (s[SAMPLE_W-1 -: 7]),
        .digit   (dec_digit),
        .invalid (dec_invalid)
    );

    // Shadow frame including the current capture, so publish can take it
    // on the same edge.
    always_comb begin
        shadow_next = shadow;
        err_next    = shadow_err;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && s_cath[i]) begin
                if (!dec_invalid) begin
                    shadow_next[i*DIGIT_W +: DIGIT_W] = dec_digit;
                end
                err_next[i] = dec_invalid;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s            <= '0;
            s_prev       <= '0;
            settle_cnt   <= '0;
            captured     <= 1'b0;
            mask         <= '0;
            shadow       <= '0;
            shadow_err   <= '0;
            timeout_cnt  <= '0;
            digits       <= '0;
            digits_valid <= 1'b0;
            err          <= '0;
            active       <= 1'b0;
        end else begin
            s      <= {segments, cathodes};
            s_prev <= s;

            if (!stable) begin
                settle_cnt <= '0;
                captured   <= 1'b0;
            end else begin
                if (settle_cnt != SETTLE_LAST) begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                if (capture) begin
                    captured <= 1'b1;
                end
            end

            shadow       <= shadow_next;
            shadow_err   <= err_next;
            digits_valid <= publish;

            if (publish) begin
                digits      <= shadow_next;
                err         <= err_next;
                mask        <= '0;
                active      <= 1'b1;
                timeout_cnt <= '0;
            end else begin
                if (capture) begin
                    mask <= mask | s_cath;
                end
                if (timeout_cnt != TIMEOUT_LAST) begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end
                // Fires once, on the edge where the counter reaches its
                // last value; while saturated, frames may assemble again.
                if (timeout_cnt == TIMEOUT_FIRE) begin
                    active <= 1'b0;
                    mask   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_capture.sv
// tb/tb_display_capture.sv - self-checking bench for display_capture
module tb_display_capture;

    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  segments;
    logic [4:0]  cathodes;
    logic [19:0] digits;
    logic        digits_valid;
    logic [4:0]  err;
    logic        active;

    always #5 clk = ~clk;

    display_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .segments     (segments),
        .cathodes     (cathodes),
        .digits       (digits),
        .digits_valid (digits_valid),
        .err          (err),
        .active       (active)
    );

    typedef struct {
        logic [7:0]  seg;
        logic [4:0]  cath;
        int          len;
        int          exp_strobes;
        logic [19:0] exp_digits;
        logic [4:0]  exp_err;
        logic        exp_active;
    } vec_t;

    vec_t        vecs[19];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          strobes = 0;
    logic [24:0] obs_q[$];
    logic [24:0] exp_q[$];
    logic [7:0]  seg_tab[10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    logic [3:0]  m_dig[5];
    logic        m_err[5];
    logic [4:0]  m_fill;
    logic [12:0] prev;
    bit          published;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Holds a bus value for len clock edges, sampling outputs on negedges.
    task automatic dwell(input logic [7:0] seg, input logic [4:0] cath, input int len);
        segments = seg;
        cathodes = cath;
        repeat (len) begin
            @(negedge clk);
            if (digits_valid) begin
                strobes++;
                obs_q.push_back({err, digits});
            end
        end
    endtask

    function automatic int decode(input logic [7:0] seg);
        for (int d = 0; d < 10; d++) begin
            if ((seg & 8'hFE) == seg_tab[d]) return d;
        end
        return -1;
    endfunction

    // Reference model: a long dwell on exactly one digit fills that slot;
    // a complete set of five slots becomes one published frame.
    task automatic put(input logic [7:0] seg, input logic [4:0] cath, input int len, input bit solid);
        int          d;
        logic [24:0] f;
        if ({seg, cath} == prev) seg[0] = ~seg[0];
        prev = {seg, cath};
        dwell(seg, cath, len);
        if (solid && $countones(cath) == 1) begin
            for (int i = 0; i < 5; i++) begin
                if (cath[i]) begin
                    d = decode(seg);
                    if (d < 0) begin
                        m_err[i] = 1'b1;
                    end else begin
                        m_dig[i] = 4'(d);
                        m_err[i] = 1'b0;
                    end
                    m_fill[i] = 1'b1;
                end
            end
            if (m_fill == 5'b11111) begin
                f = '0;
                for (int i = 0; i < 5; i++) begin
                    f[i*4 +: 4] = m_dig[i];
                    f[20 + i]   = m_err[i];
                end
                exp_q.push_back(f);
                m_fill    = '0;
                published = 1'b1;
            end
        end
    endtask

    initial begin
        int          s0;
        bit          found;
        logic [7:0]  rseg;
        logic [4:0]  rcath;
        int          n;
        int          slot;

        vecs[0]  = '{8'h60, 5'b00001, 40, 0, 20'h00000, 5'b00000, 1'b0};
        vecs[1]  = '{8'hDA, 5'b00010, 40, 0, 20'h00000, 5'b00000, 1'b0};
        vecs[2]  = '{8'hF2, 5'b00100, 40, 0, 20'h00000, 5'b00000, 1'b0};
        vecs[3]  = '{8'h00, 5'b01000, 10, 0, 20'h00000, 5'b00000, 1'b0};
        vecs[4]  = '{8'h66, 5'b01000, 40, 0, 20'h00000, 5'b00000, 1'b0};
        vecs[5]  = '{8'hB6, 5'b10000, 40, 1, 20'h54321, 5'b00000, 1'b1};
        vecs[6]  = '{8'hF6, 5'b00001, 40, 0, 20'h54321, 5'b00000, 1'b1};
        vecs[7]  = '{8'hFE, 5'b00010, 40, 0, 20'h54321, 5'b00000, 1'b1};
        vecs[8]  = '{8'hE0, 5'b00100, 40, 0, 20'h54321, 5'b00000, 1'b1};
        vecs[9]  = '{8'h60, 5'b00100, 10, 0, 20'h54321, 5'b00000, 1'b1};
        vecs[10] = '{8'h0E, 5'b01000, 40, 0, 20'h54321, 5'b00000, 1'b1};
        vecs[11] = '{8'hBE, 5'b10000, 40, 1, 20'h64789, 5'b01000, 1'b1};
        vecs[12] = '{8'hFC, 5'b00011, 100, 0, 20'h64789, 5'b01000, 1'b1};
        vecs[13] = '{8'hFC, 5'b00000, 100, 0, 20'h64789, 5'b01000, 1'b1};
        vecs[14] = '{8'hFC, 5'b00001, 40, 0, 20'h64789, 5'b01000, 1'b1};
        vecs[15] = '{8'h61, 5'b00010, 40, 0, 20'h64789, 5'b01000, 1'b1};
        vecs[16] = '{8'hDA, 5'b00100, 40, 0, 20'h64789, 5'b01000, 1'b1};
        vecs[17] = '{8'hF2, 5'b01000, 40, 0, 20'h64789, 5'b01000, 1'b1};
        vecs[18] = '{8'h66, 5'b10000, 40, 1, 20'h43210, 5'b00000, 1'b1};

        reset_n  = 1'b0;
        segments = 8'h00;
        cathodes = 5'b00000;
        repeat (3) @(negedge clk);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_valid", 32'(digits_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_active", 32'(active), 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            s0 = strobes;
            dwell(vecs[i].seg, vecs[i].cath, vecs[i].len);
            check($sformatf("vec%0d_strobes", i), 32'(strobes - s0), 32'(vecs[i].exp_strobes));
            check($sformatf("vec%0d_digits", i), 32'(digits), 32'(vecs[i].exp_digits));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_active", i), 32'(active), 32'(vecs[i].exp_active));
        end

        // Timeout: publish, then hold slot 0 static past the timeout.
        dwell(8'hFC, 5'b00001, 40);
        dwell(8'h60, 5'b00010, 40);
        dwell(8'hDA, 5'b00100, 40);
        dwell(8'hF2, 5'b01000, 40);
        segments = 8'hB6;
        cathodes = 5'b10000;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (digits_valid) found = 1'b1;
        end
        check("to_pub_seen", 32'(found), 32'h1);
        check("to_pub_digits", 32'(digits), 32'h53210);
        segments = 8'hFC;
        cathodes = 5'b00001;
        for (int k = 1; k <= 1200; k++) begin
            @(negedge clk);
            if (k == 1)   check("to_strobe_one_cycle", 32'(digits_valid), 32'h0);
            if (k == 998) check("to_active_before", 32'(active), 32'h1);
            if (k == 999) check("to_active_fall", 32'(active), 32'h0);
        end
        check("to_active_end", 32'(active), 32'h0);
        check("to_digits_hold", 32'(digits), 32'h53210);

        // Reset mid-frame discards slots 0 and 1.
        dwell(8'hB6, 5'b00001, 40);
        dwell(8'hBE, 5'b00010, 40);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_digits", 32'(digits), 32'h0);
        check("mid_rst_valid", 32'(digits_valid), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        check("mid_rst_active", 32'(active), 32'h0);
        reset_n = 1'b1;
        s0 = strobes;
        dwell(8'hE0, 5'b00100, 40);
        dwell(8'hFE, 5'b01000, 40);
        dwell(8'hF6, 5'b10000, 40);
        check("mid_partial_no_pub", 32'(strobes - s0), 32'h0);
        dwell(8'h60, 5'b00001, 40);
        dwell(8'hDA, 5'b00010, 40);
        check("mid_full_pub", 32'(strobes - s0), 32'h1);
        check("mid_digits", 32'(digits), 32'h98721);
        check("mid_err", 32'(err), 32'h0);
        check("mid_active", 32'(active), 32'h1);

        // Randomized dwells against the reference model.
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        obs_q.delete();
        for (int i = 0; i < 5; i++) begin
            m_dig[i] = '0;
            m_err[i] = 1'b0;
        end
        m_fill = '0;
        prev   = {segments, cathodes};
        for (int g = 0; g < 10; g++) begin
            published = 1'b0;
            n = 0;
            while (!published) begin
                if ($urandom_range(0, 1) == 1) begin
                    put(8'($urandom_range(0, 255)), 5'($urandom_range(0, 31)),
                        $urandom_range(1, 8), 1'b0);
                end
                if (n < 6) begin
                    n = $urandom_range(0, 9) + 0 * n + n;
                    slot = $urandom_range(0, 9);
                    if (slot < 8) begin
                        rcath = 5'b00001 << $urandom_range(0, 4);
                    end else if (slot == 8) begin
                        rcath = 5'b00000;
                    end else begin
                        rcath = 5'b00011 << $urandom_range(0, 3);
                    end
                    if ($urandom_range(0, 99) < 85) begin
                        rseg = seg_tab[$urandom_range(0, 9)] | 8'($urandom_range(0, 1));
                    end else begin
                        rseg = 8'($urandom_range(0, 255));
                    end
                end else begin
                    slot = 0;
                    for (int i = 4; i >= 0; i--) if (!m_fill[i]) slot = i;
                    rcath = 5'b00001 << slot;
                    rseg  = seg_tab[$urandom_range(0, 9)] | 8'($urandom_range(0, 1));
                end
                put(rseg, rcath, $urandom_range(25, 45), 1'b1);
                n++;
            end
            check($sformatf("rnd%0d_active", g), 32'(active), 32'h1);
        end
        check("rnd_frame_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("rnd_frame%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
